// File: rtl/tester_pkg.sv
// Shared types and defaults for the inverter tester controller.
package tester_pkg;

  localparam int unsigned DefaultWidth = 6;

  typedef enum logic [1:0] {
    StIdle,
    StSettle,
    StSample,
    StDone
  } state_e;

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for the asynchronous DUT output pins; clears to 0 on reset.
module sync2 #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/inverter_tester_ctrl.sv
// Exhaustive sweep sequencer for the hex inverter fixture: drive, settle, sample, compare
// against the complement, and report a sticky per-channel fail mask and mismatch count.
module inverter_tester_ctrl
  import tester_pkg::*;
#(
  parameter int unsigned WIDTH         = DefaultWidth,
  parameter int unsigned SETTLE_CYCLES = 50
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  output logic [WIDTH-1:0] dut_a,
  input  logic [WIDTH-1:0] dut_y,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [WIDTH-1:0] fail_mask,
  output logic [WIDTH:0]   fail_count
);

  localparam int unsigned CntW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CntW-1:0] CntLoad = CntW'(SETTLE_CYCLES - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] vec_q, vec_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] dut_a_q, dut_a_d;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic [WIDTH:0]   count_q, count_d;
  logic             pass_q, pass_d;
  logic [WIDTH-1:0] y_sync;
  logic [WIDTH-1:0] mism;

  sync2 #(
    .WIDTH (WIDTH)
  ) u_sync2 (
    .clk (clk),
    .rst (rst),
    .d   (dut_y),
    .q   (y_sync)
  );

  assign mism = y_sync ^ ~vec_q;

  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    cnt_d   = cnt_q;
    mask_d  = mask_q;
    count_d = count_q;
    pass_d  = pass_q;

    // Abort freezes all results, so a partial sample or the pass update never lands.
    if (abort) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            mask_d  = '0;
            count_d = '0;
            pass_d  = 1'b0;
            vec_d   = '0;
            cnt_d   = CntLoad;
            state_d = StSettle;
          end
        end
        StSettle: begin
          if (cnt_q == '0) begin
            state_d = StSample;
          end else begin
            cnt_d = cnt_q - CntW'(1);
          end
        end
        StSample: begin
          mask_d = mask_q | mism;
          if (|mism) begin
            count_d = count_q + (WIDTH + 1)'(1);
          end
          if (&vec_q) begin
            state_d = StDone;
          end else begin
            vec_d   = vec_q + WIDTH'(1);
            cnt_d   = CntLoad;
            state_d = StSettle;
          end
        end
        StDone: begin
          pass_d  = (mask_q == '0);
          state_d = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end

    // Registering from next-state makes the new pattern visible on the first SETTLE cycle.
    dut_a_d = (state_d == StSettle) ? vec_d : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      vec_q   <= '0;
      cnt_q   <= '0;
      dut_a_q <= '0;
      mask_q  <= '0;
      count_q <= '0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      cnt_q   <= cnt_d;
      dut_a_q <= dut_a_d;
      mask_q  <= mask_d;
      count_q <= count_d;
      pass_q  <= pass_d;
    end
  end

  assign dut_a      = dut_a_q;
  assign busy       = (state_q == StSettle) || (state_q == StSample);
  assign done       = (state_q == StDone);
  assign pass       = pass_q;
  assign fail_mask  = mask_q;
  assign fail_count = count_q;

endmodule
